// File: rtl/mem_port_arbiter_pkg.sv
// mem_port_arbiter_pkg: shared state encoding, owner codes and abort data for the memory port arbiter
package mem_port_arbiter_pkg;
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] WAIT_RSP = 2'd2;
    localparam logic OWN_IF = 1'b0;
    localparam logic OWN_D = 1'b1;
    localparam logic [31:0] TIMEOUT_DATA = 32'hDEAD_BEEF;
endpackage

// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: req/gnt/rvalid bus to the single-port memory macro
// master: arbiter side (drives req/we/addr/wdata/wstrb, receives gnt/rvalid/rdata)
// slave: memory side (the reverse)
interface mem_port_arbiter_if;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    modport master(output mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
                   input mem_gnt, mem_rvalid, mem_rdata);
    modport slave(input mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
                  output mem_gnt, mem_rvalid, mem_rdata);
endinterface

// File: rtl/mem_arb_pick.sv
// mem_arb_pick: data-priority arbitration decision with a fetch starvation counter
// en: arbitration allowed this cycle; idle: arbiter FSM is in IDLE
// if_req/d_req: requests; grant: a requester wins this cycle; owner: winner code
module mem_arb_pick import mem_port_arbiter_pkg::*; #(
    parameter int STARVE_MAX = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic idle,
    input  logic if_req,
    input  logic d_req,
    output logic grant,
    output logic owner
);
    logic [3:0] starve_cnt;
    logic       pick_if;
    // fetch wins when alone, or when data has already won STARVE_MAX times in a row over it
    assign pick_if = if_req && (!d_req || starve_cnt == 4'(STARVE_MAX));
    assign grant = en && (if_req || d_req);
    assign owner = pick_if ? OWN_IF : OWN_D;
    always_ff @(posedge clk) begin
        if (rst)
            starve_cnt <= '0;
        else if (grant && pick_if)
            starve_cnt <= '0;
        else if (grant && if_req)
            starve_cnt <= starve_cnt + 4'(starve_cnt != 4'(STARVE_MAX));
        else if (idle && !if_req)
            starve_cnt <= '0;
    end
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one req/gnt/rvalid memory port between instruction fetch and the data stage
// clk/rst: clock, synchronous active-high reset
// if_*: fetch requester (read-only); d_*: load/store requester
// mem: memory bus (master modport); err_timeout: pulse when a response never arrives
module mem_port_arbiter import mem_port_arbiter_pkg::*; #(
    parameter int STARVE_MAX = 4,
    parameter int TIMEOUT = 64
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               if_req,
    input  logic [31:0]        if_addr,
    output logic               if_done,
    output logic [31:0]        if_rdata,
    output logic               if_stall,
    input  logic               d_req,
    input  logic               d_we,
    input  logic [31:0]        d_addr,
    input  logic [31:0]        d_wdata,
    input  logic [3:0]         d_wstrb,
    output logic               d_done,
    output logic [31:0]        d_rdata,
    output logic               d_stall,
    mem_port_arbiter_if.master mem,
    output logic               err_timeout
);
    logic [1:0]  state;
    logic        owner;
    logic        r_we;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [3:0]  r_wstrb;
    logic [7:0]  to_cnt;
    logic        grant;
    logic        pick_owner;
    logic        arb_en;
    logic        fin;
    logic        pick_d;
    logic [31:0] sel_addr;
    logic [31:0] rsp_data;
    // the done cycle still sees the finished request held high, so it is not arbitrated
    assign arb_en = state == IDLE && !if_done && !d_done;
    mem_arb_pick #(.STARVE_MAX(STARVE_MAX)) u_pick (
        .clk,
        .rst,
        .en(arb_en),
        .idle(state == IDLE),
        .if_req,
        .d_req,
        .grant,
        .owner(pick_owner)
    );
    assign pick_d = pick_owner == OWN_D;
    assign sel_addr = pick_d ? d_addr : if_addr;
    assign fin = state == WAIT_RSP && (mem.mem_rvalid || to_cnt == 8'(TIMEOUT - 1));
    assign rsp_data = mem.mem_rvalid ? mem.mem_rdata : TIMEOUT_DATA;
    assign mem.mem_req = state == ISSUE;
    assign mem.mem_we = r_we;
    assign mem.mem_addr = r_addr;
    assign mem.mem_wdata = r_wdata;
    assign mem.mem_wstrb = r_wstrb;
    assign if_stall = if_req && !if_done;
    assign d_stall = d_req && !d_done;
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            owner <= OWN_IF;
            r_we <= 1'b0;
            r_addr <= '0;
            r_wdata <= '0;
            r_wstrb <= '0;
            to_cnt <= '0;
            if_done <= 1'b0;
            d_done <= 1'b0;
            err_timeout <= 1'b0;
            if_rdata <= '0;
            d_rdata <= '0;
        end else begin
            if_done <= fin && owner == OWN_IF;
            d_done <= fin && owner == OWN_D;
            err_timeout <= fin && !mem.mem_rvalid;
            if (fin && owner == OWN_IF)
                if_rdata <= rsp_data;
            if (fin && owner == OWN_D)
                d_rdata <= rsp_data;
            case (state)
                IDLE: if (grant) begin
                    owner <= pick_owner;
                    r_we <= pick_d && d_we;
                    r_addr <= sel_addr & 32'hFFFF_FFFC;
                    r_wdata <= pick_d ? d_wdata : '0;
                    r_wstrb <= pick_d && d_we ? d_wstrb : '0;
                    state <= ISSUE;
                end
                ISSUE: if (mem.mem_gnt) begin
                    state <= WAIT_RSP;
                    to_cnt <= '0;
                end
                WAIT_RSP: begin
                    to_cnt <= to_cnt + 8'd1;
                    if (fin)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
